// File: rtl/answer_checker_if.sv
// Player-facing bundle of the answer checker: round control and switches in,
// score/progress out.
interface answer_checker_if;
  logic [1:0] testcase;
  logic       start;
  logic [9:0] sw;
  logic       btn_submit;
  logic [1:0] score;
  logic       compare_finish;
  logic       busy;
  logic [2:0] entry_idx;
  logic [9:0] echo_led;

  modport master (
    output testcase, start, sw, btn_submit,
    input  score, compare_finish, busy, entry_idx, echo_led
  );

  modport slave (
    input  testcase, start, sw, btn_submit,
    output score, compare_finish, busy, entry_idx, echo_led
  );
endinterface

// File: rtl/answer_checker.sv
// Collects one-hot switch digits on each button press, compares them with the
// selected stored sequence, and reports 3 minus the (saturated) error count.
module answer_checker #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  answer_checker_if.slave   bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t        state, state_n;
  logic          btn_s1, btn_s2, btn_s3, press;
  logic          start_r, start_q, start_rise;
  logic [1:0]    tc;
  logic [2:0]    idx;
  logic [1:0]    err, err_n;
  logic [TW-1:0] timer;
  logic [9:0]    cmp, echo;
  logic          timed_out;
  logic [1:0]    score_r;
  logic          timeout_hit, entry_ok, is_last;
  logic [3:0]    expected;

  function automatic logic [3:0] seq_digit(input logic [1:0] t, input logic [2:0] i);
    logic [3:0] d;
    d = '0;
    case ({t, i})
      5'b11_000: d = 4'd9;
      5'b11_001: d = 4'd2;
      5'b11_010: d = 4'd7;
      5'b10_000: d = 4'd0;
      5'b10_001: d = 4'd4;
      5'b10_010: d = 4'd1;
      5'b10_011: d = 4'd3;
      5'b10_100: d = 4'd2;
      5'b01_000: d = 4'd1;
      5'b01_001: d = 4'd9;
      5'b01_010: d = 4'd4;
      5'b01_011: d = 4'd2;
      5'b01_100: d = 4'd0;
      5'b01_101: d = 4'd8;
      5'b01_110: d = 4'd7;
      5'b01_111: d = 4'd5;
      default:   d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] last_index(input logic [1:0] t);
    logic [2:0] l;
    l = '0;
    case (t)
      2'd3:    l = 3'd2;
      2'd2:    l = 3'd4;
      2'd1:    l = 3'd7;
      default: l = '0;
    endcase
    return l;
  endfunction

  // press is registered after the edge detector: btn rising before edge N
  // shows up as press after edge N+2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      btn_s3  <= 1'b0;
      press   <= 1'b0;
      start_r <= 1'b0;
      start_q <= 1'b0;
    end else begin
      btn_s1  <= bus.btn_submit;
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
      press   <= btn_s2 & ~btn_s3;
      start_r <= bus.start;
      start_q <= start_r;
    end
  end

  assign start_rise = start_r & ~start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    timeout_hit = (timer == TW'(TIMEOUT - 1));
    expected    = seq_digit(tc, idx);
    is_last     = (idx == last_index(tc));
    // Comparing against the decoded one-hot pattern also rejects zero or
    // multi-bit switch values.
    entry_ok    = !timed_out && (cmp == (10'd1 << expected));
    err_n       = (entry_ok || err == 2'd3) ? err : err + 2'd1;
    unique case (state)
      IDLE:  if (start_rise && bus.testcase != 2'd0) state_n = WAIT;
      WAIT:  if (press || timeout_hit) state_n = CHECK;
      CHECK: state_n = is_last ? DONE : WAIT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc        <= '0;
      idx       <= '0;
      err       <= '0;
      timer     <= '0;
      cmp       <= '0;
      echo      <= '0;
      timed_out <= 1'b0;
      score_r   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_rise && bus.testcase != 2'd0) begin
          tc        <= bus.testcase;
          idx       <= '0;
          err       <= '0;
          timer     <= '0;
          echo      <= '0;
          timed_out <= 1'b0;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (press) begin
            echo      <= bus.sw;
            cmp       <= bus.sw;
            timed_out <= 1'b0;
          end else if (timeout_hit) begin
            timed_out <= 1'b1;
          end
        end
        CHECK: begin
          err   <= err_n;
          timer <= '0;
          if (is_last) score_r <= 2'd3 - err_n;
          else         idx     <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.score          = score_r;
  assign bus.compare_finish = (state == DONE);
  assign bus.busy           = (state != IDLE);
  assign bus.entry_idx      = idx;
  assign bus.echo_led       = echo;

endmodule

// File: doc/answer_checker.md
# answer_checker

Consumes the end-of-display pulse from the LED pattern stage and collects the player's answer one digit at a time from the board switches and a submit button. Each submitted digit is compared against the stored sequence for the selected test case. Timeouts and errors are counted, and the result is reduced to a 2-bit score. On completion it returns `score` and a one-cycle `compare_finish` to the display stage, which then shows the score pattern (testcase 0) and rearms.

## Interface
- `TIMEOUT`, default 1000: clk cycles allowed per entry before it counts as wrong; must be ≥ 2.
- `clk` input 1: system clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `testcase` input 2: sequence select, sampled only at start.
  - 3 = 9,2,7
  - 2 = 0,4,1,3,2
  - 1 = 1,9,4,2,0,8,7,5
  - 0 = no sequence
- `start` input 1: level from the display stage's `is_finish`; a 0→1 transition begins a round.
- `sw` input 10: player switches; a valid digit is exactly one bit set, bit index = digit.
- `btn_submit` input 1: asynchronous push button, active-high.
- `score` output 2: result of the last round, held until the next round starts.
- `compare_finish` output 1: one-cycle pulse when `score` is updated.
- `busy` output 1: high from round start through the `compare_finish` cycle.
- `entry_idx` output 3: index of the digit currently awaited (0-based).
- `echo_led` output 10: last submitted `sw` value, held; cleared at round start.

## Operation
- **Submit path:** `btn_submit` passes through a 2-flop synchronizer, then a rising-edge detector, producing the internal one-cycle `press`.
- **Start detect:** `start` is registered, and `start_rise` = `start` & ~`start_q`.
- **FSM states:** IDLE, WAIT, CHECK, DONE.
- **IDLE:**
  - On `start_rise` with `testcase` ≠ 0, latch `tc`, set `len` = 3/5/8, and clear `idx`, `err`, timer and `echo_led`. Go to WAIT.
  - On `start_rise` with `testcase` = 0, do nothing.
- **WAIT:**
  - Timer increments every cycle.
  - On `press`, capture `sw` into `echo_led` and a compare register, then go to CHECK.
  - If timer reaches `TIMEOUT`-1 with no `press`, mark the entry wrong (`echo_led` unchanged) and go to CHECK.
  - If `press` and timeout occur in the same cycle, `press` wins.
- **CHECK (one cycle):**
  - The entry is correct iff `sw` was one-hot and its digit equals `seq[tc][idx]`.
  - On a wrong entry, `err` increments, saturating at 3.
  - Timer clears.
  - If `idx` = `len`-1, go to DONE; else `idx` increments and go to WAIT.
- **DONE (one cycle):** `score` = 3 − `err` (0 errors→3, 1→2, 2→1, ≥3→0). `compare_finish` = 1, then go to IDLE.
- **Ignored inputs:**
  - `press` is ignored outside WAIT.
  - `start_rise` is ignored outside IDLE.
  - `testcase` changes mid-round are ignored.
- **Sequence storage:** the digit sequences are a combinational ROM indexed {`tc`, `idx`}.

## Timing
- **Reset values:** all outputs 0 during reset; FSM = IDLE; synchronizer and edge flops 0.
- **Start:** `start` rising before edge N gives `start_rise` in the cycle after edge N. `busy` = 1 and `entry_idx` = 0 after the next edge.
- **Button latency:** `btn_submit` rising before edge N puts `press` high after edge N+2. CHECK is entered at edge N+3.
  - `echo_led` updates at that edge.
  - `entry_idx` advances one edge later.
- **Round length:** the last CHECK is followed by one DONE cycle. `score` and `compare_finish` change on the same edge. `busy` falls the edge after `compare_finish`.
- **Timeout:** exactly `TIMEOUT` cycles in WAIT per entry, counted from entry to WAIT.
- **Reset mid-round:** return to IDLE immediately; `score` returns to 0; no `compare_finish`.
- **Held button:** one press = one `press`; a held button does not repeat.

## Test plan
- **All correct:** reset, `testcase`=3, pulse `start`, submit `sw`=10'h200, 10'h004, 10'h080. Required: `echo_led` follows each value; `compare_finish` one cycle; `score`=3; `busy`=0 the next cycle.
- **Errors in testcase 2:** enter 0,4,1,3,2 with digit 1 entered as 5 and digit 3 as 10'h00C (not one-hot). Required: `score`=1; `entry_idx` steps 0..4.
- **Timeout with saturation:** testcase 1, `TIMEOUT`=8, no button presses. Required: `entry_idx` advances every 9 cycles (8 WAIT + 1 CHECK); after 8 entries `score`=0 (`err` saturated).
- **Ignored inputs:** a press in IDLE, `start_rise` with `testcase`=0, and `start_rise` while `busy`. Required: no state change and no `compare_finish`.
- **Held button and collision:** holding the button 20 cycles yields exactly one entry. A press arriving in the timeout cycle is evaluated as a normal entry, not a timeout.
- **Reset mid-round:** assert `reset_n`=0 at `entry_idx`=2 of testcase 2. Required: all outputs 0 immediately. A new round then completes normally with `score`=3.
